// File: rtl/uart_pkg.sv
// Shared definitions for the rx232 serial link.
// Used by the receiver today and by the transmitter later.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } rx_state_t;

    localparam int OVS        = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    // clk cycles per 16x tick, rounded to nearest
    function automatic int ovs_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVS) / 2) / (baud * OVS);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO, power-of-2 depth.
// A write into a full FIFO is dropped unless a pop happens on the same cycle.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_valid = (count != '0);
    assign do_pop   = rd_en && rd_valid;
    assign do_push  = wr_en && (!full || do_pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointers, occupancy and drop pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overrun <= wr_en && full && !do_pop;
        end
    end

endmodule

// File: rtl/uart_rx232.sv
// RS-232 receiver: 16x oversampling, 8N1 frames into a show-ahead FIFO.
// Define RX232_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx232
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 48_000_000,
    parameter int BAUD       = 115200,
    parameter int OVS_DIV    = ovs_div(CLK_HZ, BAUD),
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        rx232,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        parity_err
);

    localparam int DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int SW = $clog2(OVS);

    rx_state_t state;
    rx_state_t state_n;

    logic          sync1;
    logic          rxs;
    logic          rxs_prev;
    logic          fall;
    logic [DW-1:0] div;
    logic [SW-1:0] sub;
    logic [SW-1:0] phase;
    logic          tick;
    logic          decide;
    logic          s_lo;
    logic          s_mid;
    logic          maj;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          par_ok;
    logic          restart;
    logic          shift;
    logic          wr_en;
    logic          fe_n;

`ifdef RX232_PARITY_EN
    logic par_ld;
    logic par_bit;
    logic pe_n;
`endif

    assign fall   = rxs_prev && !rxs;
    assign tick   = (div == DW'(OVS_DIV - 1));
    assign phase  = sub + 1'b1;
    assign decide = tick && (phase == SW'(SAMPLE_HI));
    assign maj    = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
    assign busy   = (state != IDLE);

`ifdef RX232_PARITY_EN
    assign par_ok = ~^{shreg, par_bit};
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // two-flop synchronizer plus edge-detect history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync1    <= rx232;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

    // tick divider and sub-bit counter, phase-aligned to the start edge
    always_ff @(posedge clk) begin
        if (!reset_n || restart) begin
            div <= '0;
            sub <= '0;
        end else if (tick) begin
            div <= '0;
            sub <= sub + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // hold the first two of the three majority samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_lo  <= 1'b1;
            s_mid <= 1'b1;
        end else begin
            if (tick && phase == SW'(SAMPLE_LO)) begin
                s_lo <= rxs;
            end
            if (tick && phase == SW'(SAMPLE_MID)) begin
                s_mid <= rxs;
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next state and per-cycle controls
    always_comb begin
        state_n = state;
        restart = 1'b0;
        shift   = 1'b0;
        wr_en   = 1'b0;
        fe_n    = 1'b0;
`ifdef RX232_PARITY_EN
        par_ld  = 1'b0;
        pe_n    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    restart = 1'b1;
                end
            end
            START: begin
                if (decide) begin
                    state_n = maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift = 1'b1;
                    if (idx == 3'd7) begin
`ifdef RX232_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef RX232_PARITY_EN
            PARITY: begin
                if (decide) begin
                    par_ld  = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (decide) begin
                    wr_en   = maj && par_ok;
                    fe_n    = !maj;
                    state_n = maj ? IDLE : BRK;
`ifdef RX232_PARITY_EN
                    pe_n    = !par_ok;
`endif
                end
            end
            BRK: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // data shift register and bit index
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx   <= '0;
            shreg <= '0;
        end else begin
            if (restart) begin
                idx <= '0;
            end
            if (shift) begin
                shreg <= {maj, shreg[7:1]};
                idx   <= idx + 1'b1;
            end
        end
    end

    // registered error pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= fe_n;
        end
    end

`ifdef RX232_PARITY_EN
    // parity bit capture and parity error pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_ld) begin
                par_bit <= maj;
            end
            parity_err <= pe_n;
        end
    end
`endif

    rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (shreg),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (fifo_count),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_uart_rx232.sv
// Directed bench for uart_rx232 at 416 clk per bit.
// Build with RX232_PARITY_EN to add the 8E1 cases.
module tb_uart_rx232;

    localparam int BIT        = 416;
    localparam int SHORT_STOP = 260;
`ifdef RX232_PARITY_EN
    localparam int LAT_LO = 3930 + BIT;
    localparam int LAT_HI = 3990 + BIT;
`else
    localparam int LAT_LO = 3930;
    localparam int LAT_HI = 3990;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx232;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] fifo_count;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

`ifdef RX232_PARITY_EN
    logic flip_par = 1'b0;
`endif

    int n_chk    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_cyc = -1;
    int n_fe     = 0;
    int n_ov     = 0;
    int n_pe     = 0;
    int t0;
    int lat;
    int lat_use;
    int fe0;
    int ov0;
    int pe0;
    logic rv_q = 1'b0;

    always #5 clk = ~clk;

    uart_rx232 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx232      (rx232),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_count (fifo_count),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err)  n_fe++;
        if (overrun)    n_ov++;
        if (parity_err) n_pe++;
        if (rd_valid && !rv_q) rise_cyc = cyc;
        rv_q = rd_valid;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d,
                             input logic stop,
                             input int stop_len);
        rx232 = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx232 = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef RX232_PARITY_EN
        rx232 = ^d ^ flip_par;
        repeat (BIT) @(negedge clk);
`endif
        rx232 = stop;
        repeat (stop_len) @(negedge clk);
        rx232 = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rx232   = 1'b1;
        rd_en   = 1'b0;
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        repeat (20) @(negedge clk);

        // 0xA5 with latency window
        rise_cyc = -1;
        t0 = cyc;
        send_byte(8'hA5, 1'b1, SHORT_STOP);
        repeat (20) @(negedge clk);
        lat = rise_cyc - t0;
        check("a5_latency_ok", (lat >= LAT_LO && lat <= LAT_HI), 1);
        check("a5_valid", rd_valid, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_frame_err", n_fe, 0);
        check("a5_busy", busy, 0);
        pop();
        check("a5_popped", rd_valid, 0);

        // short glitch is a false start
        fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        rx232 = 1'b0;
        repeat (3) @(negedge clk);
        rx232 = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_busy_start", busy, 1);
        repeat (400) @(negedge clk);
        check("glitch_busy_end", busy, 0);
        check("glitch_valid", rd_valid, 0);
        check("glitch_pulses", (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);

        // bad stop followed by a held break
        fe0 = n_fe;
        send_byte(8'h3C, 1'b0, 2000);
        repeat (20) @(negedge clk);
        check("brk_frame_err", n_fe - fe0, 1);
        check("brk_count", fifo_count, 0);
        check("brk_busy", busy, 0);
        send_byte(8'h5A, 1'b1, SHORT_STOP);
        repeat (20) @(negedge clk);
        check("brk_next_data", rd_data, 8'h5A);
        check("brk_next_count", fifo_count, 1);
        check("brk_next_fe", n_fe - fe0, 1);
        pop();

        // fill to full, then one more
        ov0 = n_ov;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b1, SHORT_STOP);
        end
        repeat (20) @(negedge clk);
        check("fill_count", fifo_count, 16);
        check("fill_overrun", n_ov - ov0, 0);
        send_byte(8'h10, 1'b1, SHORT_STOP);
        repeat (20) @(negedge clk);
        check("ovr_count", fifo_count, 16);
        check("ovr_pulse", n_ov - ov0, 1);
        check("ovr_head", rd_data, 8'h00);

        // pop on the write cycle while full
        lat_use = (lat > 100 && lat < 5000) ? lat : 3981;
        ov0 = n_ov;
        fork
            send_byte(8'h11, 1'b1, SHORT_STOP);
            begin
                repeat (lat_use - 1) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("simul_count", fifo_count, 16);
        check("simul_overrun", n_ov - ov0, 0);
        check("simul_head", rd_data, 8'h01);
        for (int i = 1; i < 16; i++) begin
            check("pop_seq", rd_data, 32'(i));
            pop();
        end
        check("tail_data", rd_data, 8'h11);
        check("tail_count", fifo_count, 1);

        // reset in the middle of data bit 4
        fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        rx232 = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx232 = (i == 1 || i == 2);
            repeat (BIT) @(negedge clk);
        end
        rx232 = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        check("mid_busy", busy, 1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mrst_valid", rd_valid, 0);
        check("mrst_count", fifo_count, 0);
        check("mrst_data", rd_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_outs", {frame_err, overrun, parity_err}, 0);
        repeat (50) @(negedge clk);
        check("mrst_pulses", (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);
        send_byte(8'hC3, 1'b1, SHORT_STOP);
        repeat (20) @(negedge clk);
        check("post_rst_data", rd_data, 8'hC3);
        check("post_rst_count", fifo_count, 1);
        check("post_rst_fe", n_fe - fe0, 0);
        pop();

`ifdef RX232_PARITY_EN
        pe0 = n_pe;
        flip_par = 1'b0;
        send_byte(8'h07, 1'b1, SHORT_STOP);
        repeat (20) @(negedge clk);
        check("par_ok_data", rd_data, 8'h07);
        check("par_ok_pe", n_pe - pe0, 0);
        pop();
        flip_par = 1'b1;
        send_byte(8'h07, 1'b1, SHORT_STOP);
        flip_par = 1'b0;
        repeat (20) @(negedge clk);
        check("par_bad_pe", n_pe - pe0, 1);
        check("par_bad_count", fifo_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
